updown_counter: RTL and testbench

- Parametrised up/down counter: configurable width, programmable terminal value, selectable wrap or saturate mode, with load, clear and count-enable.
- Generalises the team's fixed 4-bit load/increment counter.
- Used as a reusable timer, prescaler and index generator inside datapath and control blocks.
- Registered count and event outputs feed downstream FSMs directly.

---
 rtl/updown_counter_if.sv | 26 ++
 rtl/updown_counter.sv | 78 +++++++
 tb/tb_updown_counter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/updown_counter_if.sv
// Control and status bundle for updown_counter: the owning block drives the
// controls (master) and the counter answers with its count and event flags (slave).
interface updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             enable;
    logic             up_down;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             sat_hit;
    logic             at_max;
    logic             at_zero;

    modport master (
        output clear, load, load_data, enable, up_down,
        input  count, wrap, sat_hit, at_max, at_zero
    );

    modport slave (
        input  clear, load, load_data, enable, up_down,
        output count, wrap, sat_hit, at_max, at_zero
    );
endinterface

// File: rtl/updown_counter.sv
// Parametrised up/down counter with a programmable terminal value, wrap or
// saturate overflow, load with clamping, clear and registered event pulses.
module updown_counter #(
    parameter int             WIDTH       = 8,
    parameter logic [WIDTH-1:0] MAX_VALUE = '1,
    parameter bit             SATURATE    = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    updown_counter_if.slave   bus
);

    if (WIDTH < 2 || WIDTH > 32 || MAX_VALUE == '0 || RESET_VALUE > MAX_VALUE) begin : g_bad_params
        $error("updown_counter: illegal parameters WIDTH=%0d MAX_VALUE=%0d RESET_VALUE=%0d",
               WIDTH, MAX_VALUE, RESET_VALUE);
    end

    localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX_VALUE};
    localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             sat_hit_q;
    logic [WIDTH:0]   step_up;
    logic [WIDTH:0]   step_down;

    // One extra bit: a step past MAX_VALUE shows as a value above MAX_EXT,
    // a step below zero shows as the borrow in the top bit.
    assign step_up   = {1'b0, count_q} + ONE_EXT;
    assign step_down = {1'b0, count_q} - ONE_EXT;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the reset branch sits inside the clocked
    // block because reset is synchronous here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q   <= RESET_VALUE;
            wrap_q    <= 1'b0;
            sat_hit_q <= 1'b0;
        end else begin
            wrap_q    <= 1'b0;
            sat_hit_q <= 1'b0;
            if (bus.clear) begin
                count_q <= RESET_VALUE;
            end else if (bus.load) begin
                count_q <= (bus.load_data > MAX_VALUE) ? MAX_VALUE : bus.load_data;
            end else if (bus.enable) begin
                if (bus.up_down) begin
                    if (step_up <= MAX_EXT) begin
                        count_q <= step_up[WIDTH-1:0];
                    end else if (SATURATE) begin
                        sat_hit_q <= 1'b1;
                    end else begin
                        count_q <= '0;
                        wrap_q  <= 1'b1;
                    end
                end else begin
                    if (!step_down[WIDTH]) begin
                        count_q <= step_down[WIDTH-1:0];
                    end else if (SATURATE) begin
                        sat_hit_q <= 1'b1;
                    end else begin
                        count_q <= MAX_VALUE;
                        wrap_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.wrap    = wrap_q;
    assign bus.sat_hit = sat_hit_q;
    assign bus.at_max  = (count_q == MAX_VALUE);
    assign bus.at_zero = (count_q == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: mod-10 wrap counter, mod-10 saturating
// counter and a default 8-bit counter, all sharing one clock and reset.
module tb_updown_counter;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    updown_counter_if #(.WIDTH(4)) a_if ();
    updown_counter_if #(.WIDTH(4)) b_if ();
    updown_counter_if #(.WIDTH(8)) c_if ();

    updown_counter #(.WIDTH(4), .MAX_VALUE(4'd9), .SATURATE(1'b0), .RESET_VALUE(4'd0)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .bus(a_if.slave));
    updown_counter #(.WIDTH(4), .MAX_VALUE(4'd9), .SATURATE(1'b1), .RESET_VALUE(4'd0)) dut_sat (
        .clk(clk), .reset_n(reset_n), .bus(b_if.slave));
    updown_counter dut_def (
        .clk(clk), .reset_n(reset_n), .bus(c_if.slave));

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Inputs change 1 ns after the edge and outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        {a_if.clear, a_if.load, a_if.enable, a_if.up_down} = '0; a_if.load_data = '0;
        {b_if.clear, b_if.load, b_if.enable, b_if.up_down} = '0; b_if.load_data = '0;
        {c_if.clear, c_if.load, c_if.enable, c_if.up_down} = '0; c_if.load_data = '0;
        step(); step();

        check("rst_count",   32'(a_if.count),   0);
        check("rst_wrap",    32'(a_if.wrap),    0);
        check("rst_sat_hit", 32'(b_if.sat_hit), 0);
        check("rst_at_zero", 32'(a_if.at_zero), 1);
        check("rst_at_max",  32'(a_if.at_max),  0);
        check("rst_c_count", 32'(c_if.count),   0);

        // Up-count through the terminal value of a mod-10 counter.
        reset_n = 1'b1;
        a_if.enable = 1'b1; a_if.up_down = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("up_count_%0d", i), 32'(a_if.count),   32'(i % 10));
            check($sformatf("up_wrap_%0d", i),  32'(a_if.wrap),    32'(i == 10));
            check($sformatf("up_max_%0d", i),   32'(a_if.at_max),  32'(i % 10 == 9));
            check($sformatf("up_zero_%0d", i),  32'(a_if.at_zero), 32'(i % 10 == 0));
        end

        // Load 0, then count down across zero.
        a_if.enable = 1'b0; a_if.load = 1'b1; a_if.load_data = 4'd0;
        step();
        check("ld0_count", 32'(a_if.count),   0);
        check("ld0_zero",  32'(a_if.at_zero), 1);
        a_if.load = 1'b0; a_if.enable = 1'b1; a_if.up_down = 1'b0;
        step();
        check("dn_count_1", 32'(a_if.count), 9);
        check("dn_wrap_1",  32'(a_if.wrap),  1);
        check("dn_zero_1",  32'(a_if.at_zero), 0);
        step();
        check("dn_count_2", 32'(a_if.count), 8);
        check("dn_wrap_2",  32'(a_if.wrap),  0);
        step();
        check("dn_count_3", 32'(a_if.count), 7);
        check("dn_wrap_3",  32'(a_if.wrap),  0);
        a_if.enable = 1'b0;

        // Saturating counter: hold at MAX_VALUE and at zero.
        b_if.load = 1'b1; b_if.load_data = 4'd8;
        step();
        check("sat_ld8", 32'(b_if.count), 8);
        b_if.load = 1'b0; b_if.enable = 1'b1; b_if.up_down = 1'b1;
        step();
        check("sat_up_count_1", 32'(b_if.count),   9);
        check("sat_up_hit_1",   32'(b_if.sat_hit), 0);
        step();
        check("sat_up_count_2", 32'(b_if.count),   9);
        check("sat_up_hit_2",   32'(b_if.sat_hit), 1);
        check("sat_up_wrap_2",  32'(b_if.wrap),    0);
        step();
        check("sat_up_count_3", 32'(b_if.count),   9);
        check("sat_up_hit_3",   32'(b_if.sat_hit), 1);
        check("sat_up_wrap_3",  32'(b_if.wrap),    0);
        b_if.enable = 1'b0; b_if.load = 1'b1; b_if.load_data = 4'd1;
        step();
        check("sat_ld1",      32'(b_if.count),   1);
        check("sat_ld1_hit",  32'(b_if.sat_hit), 0);
        b_if.load = 1'b0; b_if.enable = 1'b1; b_if.up_down = 1'b0;
        step();
        check("sat_dn_count_1", 32'(b_if.count),   0);
        check("sat_dn_hit_1",   32'(b_if.sat_hit), 0);
        step();
        check("sat_dn_count_2", 32'(b_if.count),   0);
        check("sat_dn_hit_2",   32'(b_if.sat_hit), 1);
        check("sat_dn_wrap_2",  32'(b_if.wrap),    0);
        b_if.enable = 1'b0;
        step();
        check("sat_idle_hit", 32'(b_if.sat_hit), 0);

        // Priority: clear > load > enable, and load clamping.
        a_if.load = 1'b1; a_if.load_data = 4'd5;
        step();
        check("pri_ld5", 32'(a_if.count), 5);
        a_if.clear = 1'b1; a_if.load_data = 4'd7; a_if.enable = 1'b1; a_if.up_down = 1'b1;
        step();
        check("pri_clear", 32'(a_if.count), 0);
        check("pri_clear_wrap", 32'(a_if.wrap), 0);
        a_if.clear = 1'b0;
        step();
        check("pri_load_over_en", 32'(a_if.count), 7);
        a_if.load_data = 4'd14;
        step();
        check("ld_clamp", 32'(a_if.count), 9);
        check("ld_clamp_max", 32'(a_if.at_max), 1);
        check("ld_clamp_wrap", 32'(a_if.wrap), 0);

        // Reset mid-count with a simultaneous load.
        a_if.load_data = 4'd5;
        step();
        a_if.load = 1'b0;
        step();
        check("pre_rst_count", 32'(a_if.count), 6);
        reset_n = 1'b0; a_if.load = 1'b1; a_if.load_data = 4'd3;
        step();
        check("mid_rst_count", 32'(a_if.count),   0);
        check("mid_rst_wrap",  32'(a_if.wrap),    0);
        check("mid_rst_sat",   32'(a_if.sat_hit), 0);
        reset_n = 1'b1; a_if.load = 1'b0;
        step();
        check("post_rst_count", 32'(a_if.count), 1);

        // Reset must suppress a wrap that would otherwise occur this edge.
        a_if.load = 1'b1; a_if.load_data = 4'd9;
        step();
        a_if.load = 1'b0; reset_n = 1'b0;
        step();
        check("rst_blocks_wrap", 32'(a_if.wrap), 0);
        reset_n = 1'b1; a_if.enable = 1'b0;

        // Default 8-bit counter: natural wrap both ways, then hold.
        c_if.load = 1'b1; c_if.load_data = 8'd255;
        step();
        check("def_ld255", 32'(c_if.count), 255);
        check("def_at_max", 32'(c_if.at_max), 1);
        c_if.load = 1'b0; c_if.enable = 1'b1; c_if.up_down = 1'b1;
        step();
        check("def_up_count", 32'(c_if.count), 0);
        check("def_up_wrap",  32'(c_if.wrap),  1);
        c_if.up_down = 1'b0;
        step();
        check("def_dn_count", 32'(c_if.count), 255);
        check("def_dn_wrap",  32'(c_if.wrap),  1);
        c_if.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("def_hold_count_%0d", i), 32'(c_if.count),   255);
            check($sformatf("def_hold_wrap_%0d", i),  32'(c_if.wrap),    0);
            check($sformatf("def_hold_sat_%0d", i),   32'(c_if.sat_hit), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
